alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers; successor to the single-cycle hilo ALU.
//  Sits in EX beside the main ALU; multi-cycle ops run in the background, and the pipeline stalls only on a HI/LO hazard.
//  Generalised in width and in iteration step (bits retired per cycle). Adds signed/unsigned divide, a start/ready handshake and flush.
// PARAMETERS
//  DATA_W   32  operand, HI and LO width; must be even and >=4
//  STEP     1   bits retired per RUN cycle; power of 2; must divide DATA_W
//  ITER     DATA_W/STEP (localparam)  RUN cycles per op
// PORTS
//  ctrl     in   `Util_Control_T  control bundle; clock = `Util_Control_clock(ctrl), reset = `Util_Control_reset(ctrl): one clock, async active-high reset
//  func     in   `Alu_Func_T  Mult/Multu/Div/Divu/Mthi/Mtlo/Mfhi/Mflo; any other code = no-op
//  valid    in   1       func/data qualified this cycle
//  data1    in   DATA_W  rs: multiplicand/dividend; source for Mthi/Mtlo
//  data2    in   DATA_W  rt: multiplier/divisor
//  flush    in   1       cancel in-flight op (pipeline exception)
//  ready    out  1       op accepted this cycle when valid&ready
//  busy     out  1       multi-cycle op in flight
//  stall    out  1       valid & HI/LO-touching func & busy
//  result   out  DATA_W  Mfhi/Mflo read data, combinational from HI/LO
//  hi, lo   out  DATA_W  architectural registers (debug/forwarding)
//  div_zero out  1       sticky: last divide had divisor 0
//  div_ovf  out  1       sticky: last signed divide was MIN/-1
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; hi=lo=0; busy=0; div_zero=div_ovf=0; result=0.
//  FSM IDLE -> RUN -> FIXUP -> IDLE.
//   IDLE: ready=1. valid & Mult/Multu/Div/Divu -> latch operand magnitudes and signs; go to RUN. Clear div_zero/div_ovf on divide issue.
//   RUN: ITER cycles driven by a down-counter. Shift-add multiply, or restoring divide, STEP bits per cycle.
//   FIXUP: one cycle. Apply sign correction; write hi/lo; go to IDLE. busy is high for exactly ITER+1 cycles after acceptance.
//  Mthi/Mtlo: single-cycle write of data1 when valid & ~busy. Mfhi/Mflo: result=hi/lo when ~busy. No other state change.
//  Busy: ready=0 and no op is accepted. stall=1 for any HI/LO func; the op stays pending and is not queued.
//  Mult: {hi,lo} = signed 2*DATA_W product; Multu unsigned. No overflow flag.
//  Div: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend. Divu unsigned.
//  Divisor 0: hi=data1, lo=all ones, div_zero=1; still takes the full ITER+1 cycles.
//  Signed MIN/-1: lo=MIN, hi=0, div_ovf=1.
//  flush in RUN/FIXUP: return to IDLE next edge; hi/lo and flags unchanged. flush&valid same cycle: flush wins, nothing accepted.
//  FIXUP & flush same cycle: flush wins and the write is suppressed.
//  Reset mid-op: abandons the op; all outputs take their reset values.
// CONFIGURATION
//  ALU_MULDIV_MACC_EN defined: adds Madd/Maddu/Msub/Msubu; the product is added to or subtracted from {hi,lo} in FIXUP, modulo 2^(2*DATA_W).
//  Not defined: those func codes are no-ops; no accumulate adder is synthesised.
// STRUCTURE
//  New func codes (Mult, Multu, Div, Divu, Mtlo, Madd*, Msub*) join the shared ALU func header next to the existing `Alu_Func_* codes.
//  FSM state encoding stays local.
//  Sub-module alu_muldiv_step: combinational STEP-bit shift-add / restore-subtract slice, instantiated once.
//  alu_muldiv owns the FSM, counter, sign handling and HI/LO.
// TESTING (DATA_W=4, STEP=1 unless noted)
//  Mult 7*3 -> after 5 busy cycles hi=1 lo=5; Multu a*a -> hi=6 lo=4; Mult f*f (-1*-1) -> hi=0 lo=1.
//  Div 7/2 -> lo=3 hi=1; Div 9/2 (-7/2) -> lo=d hi=f; Divu 9/2 -> lo=4 hi=1.
//  Div 5/0 -> hi=5 lo=f div_zero=1; Div 8/f (MIN/-1) -> lo=8 hi=0 div_ovf=1.
//  Mfhi during busy -> stall=1, ready=0; read returns the new hi after busy falls.
//  Mthi a then Mflo -> hi=a, lo unchanged.
//  Flush at RUN cycle 2 -> hi/lo keep prior values, busy=0 next cycle.
//  Reset asserted mid-RUN -> all zero immediately.
//  Rerun the Mult/Div cases with STEP=2 -> same results, busy for 3 cycles.
//  With ALU_MULDIV_MACC_EN, Madd 2*3 onto {0,1} -> lo=7.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared types for the multiply/divide unit: the control bundle (clock and
// reset) and the ALU function codes, including the HI/LO codes added with
// this unit.
package alu_muldiv_pkg;

  // One clock and one asynchronous active-high reset travel together.
  typedef struct packed {
    logic clock;
    logic reset;
  } util_control_t;

  // ALU function header. Codes not listed here are no-ops for alu_muldiv.
  // The Madd/Msub codes always exist, but only ALU_MULDIV_MACC_EN builds
  // act on them.
  typedef enum logic [3:0] {
    ALU_FUNC_NOP   = 4'h0,
    ALU_FUNC_MFHI  = 4'h1,
    ALU_FUNC_MFLO  = 4'h2,
    ALU_FUNC_MTHI  = 4'h3,
    ALU_FUNC_MTLO  = 4'h4,
    ALU_FUNC_MULT  = 4'h5,
    ALU_FUNC_MULTU = 4'h6,
    ALU_FUNC_DIV   = 4'h7,
    ALU_FUNC_DIVU  = 4'h8,
    ALU_FUNC_MADD  = 4'h9,
    ALU_FUNC_MADDU = 4'ha,
    ALU_FUNC_MSUB  = 4'hb,
    ALU_FUNC_MSUBU = 4'hc
  } alu_func_t;

endpackage

// File: rtl/alu_muldiv_step.sv
// Combinational datapath slice that retires STEP bits per call.
// Ports: is_div selects the operation, p_in/p_out carry the working register,
//        opnd is the multiplicand or divisor magnitude.
// Multiply: p = {partial_hi, multiplier}. Each bit conditionally adds opnd
//           to the upper half, then shifts right, keeping the carry.
// Divide:   p = {remainder, dividend/quotient}. Each bit shifts left and
//           subtracts opnd when the difference does not borrow (restoring).
module alu_muldiv_step
  import alu_muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 1
) (
  input  logic                  is_div,
  input  logic [2*DATA_W-1:0]   p_in,
  input  logic [DATA_W-1:0]     opnd,
  output logic [2*DATA_W-1:0]   p_out
);

  logic [2*DATA_W-1:0] p;
  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     diff;
  logic [DATA_W:0]     sum;

  always_comb begin
    p       = p_in;
    shifted = '0;
    diff    = '0;
    sum     = '0;
    for (int i = 0; i < STEP; i++) begin
      if (is_div) begin
        // The remainder stays below the divisor, so the shifted value needs
        // only one extra bit, and diff's top bit is the borrow.
        shifted = p[2*DATA_W-1:DATA_W-1];
        diff    = shifted - {1'b0, opnd};
        if (diff[DATA_W])
          p = {shifted[DATA_W-1:0], p[DATA_W-2:0], 1'b0};
        else
          p = {diff[DATA_W-1:0], p[DATA_W-2:0], 1'b1};
      end else begin
        sum = {1'b0, p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, opnd} : '0);
        p   = {sum, p[DATA_W-1:1]};
      end
    end
    p_out = p;
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports: ctrl (clock + async active-high reset), func/valid/data1/data2 issue,
//        flush cancels an in-flight op. ready/busy/stall provide the handshake.
//        result gives the Mfhi/Mflo read, hi/lo expose the registers, and
//        div_zero/div_ovf hold sticky divide flags.
// Optional macro ALU_MULDIV_MACC_EN adds Madd/Maddu/Msub/Msubu accumulate.
// Timing: an accepted op is busy for ITER RUN cycles and one FIXUP cycle, where
// ITER = DATA_W/STEP. Signs are stripped at issue and reapplied in FIXUP.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 1
) (
  input  util_control_t      ctrl,
  input  alu_func_t          func,
  input  logic               valid,
  input  logic [DATA_W-1:0]  data1,
  input  logic [DATA_W-1:0]  data2,
  input  logic               flush,
  output logic               ready,
  output logic               busy,
  output logic               stall,
  output logic [DATA_W-1:0]  result,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo,
  output logic               div_zero,
  output logic               div_ovf
);

  localparam int ITER  = DATA_W / STEP;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_t;

  logic clk;
  logic rst;
  assign clk = ctrl.clock;
  assign rst = ctrl.reset;

  state_t state_q, state_d;

  // ---------------- issue decode ----------------
  logic is_macc, is_mul, is_div, is_sgn, is_hilo, accept;
  logic s1, s2;
  logic [DATA_W-1:0] m1, m2;

`ifdef ALU_MULDIV_MACC_EN
  assign is_macc = func inside {ALU_FUNC_MADD, ALU_FUNC_MADDU,
                                ALU_FUNC_MSUB, ALU_FUNC_MSUBU};
`else
  assign is_macc = 1'b0;
`endif
  assign is_mul  = (func inside {ALU_FUNC_MULT, ALU_FUNC_MULTU}) | is_macc;
  assign is_div  = func inside {ALU_FUNC_DIV, ALU_FUNC_DIVU};
  assign is_sgn  = func inside {ALU_FUNC_MULT, ALU_FUNC_DIV,
                                ALU_FUNC_MADD, ALU_FUNC_MSUB};
  assign is_hilo = is_mul | is_div |
                   (func inside {ALU_FUNC_MTHI, ALU_FUNC_MTLO,
                                 ALU_FUNC_MFHI, ALU_FUNC_MFLO});

  assign busy   = (state_q != S_IDLE);
  assign ready  = ~busy;
  assign stall  = valid & is_hilo & busy;
  // flush wins over a same-cycle issue
  assign accept = valid & ~busy & ~flush & (is_mul | is_div);

  // Magnitudes: MIN negates to itself, which reads correctly as unsigned 2^(W-1).
  assign s1 = is_sgn & data1[DATA_W-1];
  assign s2 = is_sgn & data2[DATA_W-1];
  assign m1 = s1 ? -data1 : data1;
  assign m2 = s2 ? -data2 : data2;

  // ---------------- op state ----------------
  alu_func_t            op_q;
  logic [2*DATA_W-1:0]  p_q, p_nxt;
  logic [DATA_W-1:0]    opnd_q, d1_q;
  logic                 neg_a_q;   // negate product / quotient
  logic                 neg_r_q;   // negate remainder (dividend sign)
  logic                 dz_q, ovf_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 op_is_div;
  logic                 load, fix_wr;

  assign op_is_div = op_q inside {ALU_FUNC_DIV, ALU_FUNC_DIVU};

  alu_muldiv_step #(.DATA_W(DATA_W), .STEP(STEP)) u_step (
    .is_div (op_is_div),
    .p_in   (p_q),
    .opnd   (opnd_q),
    .p_out  (p_nxt)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    fix_wr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (flush)              state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_FIXUP;
      end
      S_FIXUP: begin
        state_d = S_IDLE;
        fix_wr  = ~flush;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FIXUP result ----------------
  logic [2*DATA_W-1:0] prod, hilo_new;
  logic [DATA_W-1:0]   quo, rem;

  always_comb begin
    prod     = neg_a_q ? -p_q : p_q;
    quo      = neg_a_q ? -p_q[DATA_W-1:0] : p_q[DATA_W-1:0];
    rem      = neg_r_q ? -p_q[2*DATA_W-1:DATA_W] : p_q[2*DATA_W-1:DATA_W];
    hilo_new = prod;
    if (op_is_div) begin
      if (dz_q)       hilo_new = {d1_q, {DATA_W{1'b1}}};
      else if (ovf_q) hilo_new = {{DATA_W{1'b0}}, MIN_V};
      else            hilo_new = {rem, quo};
    end
`ifdef ALU_MULDIV_MACC_EN
    else if (op_q inside {ALU_FUNC_MADD, ALU_FUNC_MADDU})
      hilo_new = {hi, lo} + prod;
    else if (op_q inside {ALU_FUNC_MSUB, ALU_FUNC_MSUBU})
      hilo_new = {hi, lo} - prod;
`endif
  end

  // ---------------- datapath and HI/LO ----------------
  logic wr_hi, wr_lo;
  assign wr_hi = valid & ~busy & ~flush & (func == ALU_FUNC_MTHI);
  assign wr_lo = valid & ~busy & ~flush & (func == ALU_FUNC_MTLO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= ALU_FUNC_NOP;
      p_q      <= '0;
      opnd_q   <= '0;
      d1_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
    end else begin
      if (load) begin
        op_q    <= func;
        d1_q    <= data1;
        opnd_q  <= is_div ? m2 : m1;
        p_q     <= {{DATA_W{1'b0}}, (is_div ? m1 : m2)};
        neg_a_q <= s1 ^ s2;
        neg_r_q <= s1;
        dz_q    <= (data2 == '0);
        ovf_q   <= is_div & is_sgn & (data1 == MIN_V) & (&data2);
        cnt_q   <= CNT_W'(ITER - 1);
        if (is_div) begin
          div_zero <= 1'b0;
          div_ovf  <= 1'b0;
        end
      end else if (state_q == S_RUN) begin
        p_q   <= p_nxt;
        cnt_q <= cnt_q - 1'b1;
      end
      if (fix_wr) begin
        {hi, lo} <= hilo_new;
        if (op_is_div) begin
          div_zero <= dz_q;
          div_ovf  <= ovf_q;
        end
      end
      if (wr_hi) hi <= data1;
      if (wr_lo) lo <= data1;
    end
  end

  // Read port: only meaningful for Mfhi/Mflo while idle, zero otherwise.
  always_comb begin
    result = '0;
    if (valid && !busy) begin
      if (func == ALU_FUNC_MFHI)      result = hi;
      else if (func == ALU_FUNC_MFLO) result = lo;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  util_control_t ctrl;
  assign ctrl = '{clock: clk, reset: rst};

  alu_func_t func;
  logic valid, flush;
  logic [W-1:0] data1, data2;

  logic ready1, busy1, stall1, dz1, ov1;
  logic [W-1:0] result1, hi1, lo1;
  logic ready2, busy2, stall2, dz2, ov2;
  logic [W-1:0] result2, hi2, lo2;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_hi, m_lo;
  logic m_dz, m_ov;

  always #5 clk = ~clk;

  alu_muldiv #(.DATA_W(W), .STEP(1)) u_dut1 (
    .ctrl(ctrl), .func(func), .valid(valid), .data1(data1), .data2(data2),
    .flush(flush), .ready(ready1), .busy(busy1), .stall(stall1),
    .result(result1), .hi(hi1), .lo(lo1), .div_zero(dz1), .div_ovf(ov1)
  );

  alu_muldiv #(.DATA_W(W), .STEP(2)) u_dut2 (
    .ctrl(ctrl), .func(func), .valid(valid), .data1(data1), .data2(data2),
    .flush(flush), .ready(ready2), .busy(busy2), .stall(stall2),
    .result(result2), .hi(hi2), .lo(lo2), .div_zero(dz2), .div_ovf(ov2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural effect of one op, from plain integer arithmetic.
  task automatic model_op(input alu_func_t f, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, ua, ub, x, y, p, q, r;
    logic [7:0] acc, pv;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    case (f)
      ALU_FUNC_MULT:  begin p = sa * sb; pv = p[7:0]; {m_hi, m_lo} = pv; end
      ALU_FUNC_MULTU: begin p = ua * ub; pv = p[7:0]; {m_hi, m_lo} = pv; end
      ALU_FUNC_DIV, ALU_FUNC_DIVU: begin
        if (f == ALU_FUNC_DIV) begin x = sa; y = sb; end
        else begin x = ua; y = ub; end
        m_dz = (b == 0);
        m_ov = (f == ALU_FUNC_DIV) && (sa == -8) && (sb == -1);
        if (m_dz) begin m_hi = a; m_lo = 4'hf; end
        else if (m_ov) begin m_hi = 4'h0; m_lo = 4'h8; end
        else begin q = x / y; r = x % y; m_hi = r[3:0]; m_lo = q[3:0]; end
      end
      ALU_FUNC_MTHI: m_hi = a;
      ALU_FUNC_MTLO: m_lo = a;
`ifdef ALU_MULDIV_MACC_EN
      ALU_FUNC_MADD, ALU_FUNC_MADDU, ALU_FUNC_MSUB, ALU_FUNC_MSUBU: begin
        if (f == ALU_FUNC_MADD || f == ALU_FUNC_MSUB) p = sa * sb;
        else p = ua * ub;
        pv  = p[7:0];
        acc = {m_hi, m_lo};
        if (f == ALU_FUNC_MADD || f == ALU_FUNC_MADDU) acc = acc + pv;
        else acc = acc - pv;
        {m_hi, m_lo} = acc;
      end
`endif
      default: ;
    endcase
  endtask

  // Multi-cycle op: issue, count busy cycles on both units, then compare.
  task automatic run_op(input string tag, input alu_func_t f,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    int n1, n2;
    bit done;
    func = f; valid = 1'b1; data1 = a; data2 = b; #1;
    chk({tag, "/ready1"}, ready1, 1);
    chk({tag, "/ready2"}, ready2, 1);
    @(negedge clk);
    valid = 1'b0; func = ALU_FUNC_NOP;
    n1 = 0; n2 = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (busy1) n1++;
      if (busy2) n2++;
      if (!busy1 && !busy2) done = 1;
      else @(negedge clk);
    end
    chk({tag, "/idle"}, {busy1, busy2}, 0);
    model_op(f, a, b);
    chk({tag, "/busy_cycles1"}, n1, 5);
    chk({tag, "/busy_cycles2"}, n2, 3);
    chk({tag, "/hi1"}, hi1, m_hi);
    chk({tag, "/lo1"}, lo1, m_lo);
    chk({tag, "/hi2"}, hi2, m_hi);
    chk({tag, "/lo2"}, lo2, m_lo);
    if (f == ALU_FUNC_DIV || f == ALU_FUNC_DIVU) begin
      chk({tag, "/div_zero1"}, dz1, m_dz);
      chk({tag, "/div_ovf1"}, ov1, m_ov);
      chk({tag, "/div_zero2"}, dz2, m_dz);
      chk({tag, "/div_ovf2"}, ov2, m_ov);
    end
  endtask

  // Single-cycle or no-op code.
  task automatic quick_op(input string tag, input alu_func_t f, input logic [W-1:0] a);
    func = f; valid = 1'b1; data1 = a; data2 = '0;
    @(negedge clk);
    valid = 1'b0; func = ALU_FUNC_NOP; #1;
    model_op(f, a, '0);
    chk({tag, "/busy"}, {busy1, busy2}, 0);
    chk({tag, "/hi1"}, hi1, m_hi);
    chk({tag, "/lo1"}, lo1, m_lo);
    chk({tag, "/hi2"}, hi2, m_hi);
    chk({tag, "/lo2"}, lo2, m_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int sel;
    func = ALU_FUNC_NOP; valid = 1'b0; flush = 1'b0; data1 = '0; data2 = '0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0; m_ov = 1'b0;

    // Reset state
    #2 rst = 1'b1; #1;
    chk("rst/hi1", hi1, 0);
    chk("rst/lo1", lo1, 0);
    chk("rst/busy1", busy1, 0);
    chk("rst/ready1", ready1, 1);
    chk("rst/flags1", {dz1, ov1}, 0);
    chk("rst/result1", result1, 0);
    chk("rst/hilo2", {hi2, lo2, busy2}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic cases
    run_op("mult_7x3",  ALU_FUNC_MULT,  4'h7, 4'h3);
    run_op("multu_axa", ALU_FUNC_MULTU, 4'ha, 4'ha);
    run_op("mult_fxf",  ALU_FUNC_MULT,  4'hf, 4'hf);
    run_op("div_7_2",   ALU_FUNC_DIV,   4'h7, 4'h2);
    run_op("div_9_2",   ALU_FUNC_DIV,   4'h9, 4'h2);
    run_op("divu_9_2",  ALU_FUNC_DIVU,  4'h9, 4'h2);
    run_op("div_5_0",   ALU_FUNC_DIV,   4'h5, 4'h0);
    run_op("div_8_f",   ALU_FUNC_DIV,   4'h8, 4'hf);

    // Mfhi while busy stalls, then reads the new hi
    func = ALU_FUNC_MULT; valid = 1'b1; data1 = 4'h7; data2 = 4'h7;
    @(negedge clk);
    func = ALU_FUNC_MFHI; #1;
    chk("mfhi_busy/stall1", stall1, 1);
    chk("mfhi_busy/ready1", ready1, 0);
    chk("mfhi_busy/stall2", stall2, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!busy1) break;
    end
    model_op(ALU_FUNC_MULT, 4'h7, 4'h7);
    chk("mfhi_busy/done", busy1, 0);
    chk("mfhi_busy/result1", result1, m_hi);
    chk("mfhi_busy/result2", result2, m_hi);
    valid = 1'b0; func = ALU_FUNC_NOP;

    // Mthi a then Mflo
    func = ALU_FUNC_MTHI; valid = 1'b1; data1 = 4'ha;
    @(negedge clk);
    model_op(ALU_FUNC_MTHI, 4'ha, 4'h0);
    func = ALU_FUNC_MFLO; data1 = '0; #1;
    chk("mthi/hi1", hi1, 4'ha);
    chk("mthi/lo1", lo1, m_lo);
    chk("mflo/result1", result1, m_lo);
    valid = 1'b0; func = ALU_FUNC_NOP;
    @(negedge clk);

    // Flush during FIXUP of the STEP=1 unit suppresses the write
    func = ALU_FUNC_MULT; valid = 1'b1; data1 = 4'h7; data2 = 4'h3;
    @(negedge clk);
    valid = 1'b0; func = ALU_FUNC_NOP;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; #1;
    chk("fixup_flush/busy1", busy1, 0);
    chk("fixup_flush/hi1", hi1, m_hi);
    chk("fixup_flush/lo1", lo1, m_lo);

    // Reset mid-RUN clears everything at once
    @(negedge clk);
    func = ALU_FUNC_MULT; valid = 1'b1; data1 = 4'h7; data2 = 4'h3;
    @(negedge clk);
    valid = 1'b0; func = ALU_FUNC_NOP;
    @(negedge clk);
    rst = 1'b1; #1;
    m_hi = '0; m_lo = '0; m_dz = 1'b0; m_ov = 1'b0;
    chk("midrst/busy1", busy1, 0);
    chk("midrst/hi1", hi1, 0);
    chk("midrst/lo1", lo1, 0);
    chk("midrst/flags1", {dz1, ov1}, 0);
    chk("midrst/all2", {busy2, hi2, lo2, dz2, ov2}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Flush at RUN cycle 2 keeps prior hi/lo
    quick_op("mthi_5", ALU_FUNC_MTHI, 4'h5);
    quick_op("mtlo_6", ALU_FUNC_MTLO, 4'h6);
    func = ALU_FUNC_DIV; valid = 1'b1; data1 = 4'h7; data2 = 4'h2;
    @(negedge clk);
    valid = 1'b0; func = ALU_FUNC_NOP;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; #1;
    chk("run_flush/busy", {busy1, busy2}, 0);
    chk("run_flush/hi1", hi1, m_hi);
    chk("run_flush/lo1", lo1, m_lo);
    chk("run_flush/hi2", hi2, m_hi);
    chk("run_flush/lo2", lo2, m_lo);

    // flush and valid together: nothing accepted
    func = ALU_FUNC_MULT; valid = 1'b1; flush = 1'b1; data1 = 4'h7; data2 = 4'h3;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0; func = ALU_FUNC_NOP; #1;
    chk("flush_valid/busy", {busy1, busy2}, 0);
    chk("flush_valid/hi1", hi1, m_hi);
    chk("flush_valid/lo1", lo1, m_lo);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 6);
      ra  = W'($urandom);
      rb  = W'($urandom);
      if ($urandom_range(0, 7) == 0) rb = '0;
      case (sel)
        0: run_op("rnd_mult",  ALU_FUNC_MULT,  ra, rb);
        1: run_op("rnd_multu", ALU_FUNC_MULTU, ra, rb);
        2: run_op("rnd_div",   ALU_FUNC_DIV,   ra, rb);
        3: run_op("rnd_divu",  ALU_FUNC_DIVU,  ra, rb);
        4: quick_op("rnd_mthi", ALU_FUNC_MTHI, ra);
        5: quick_op("rnd_mtlo", ALU_FUNC_MTLO, ra);
        default: quick_op("rnd_nop", alu_func_t'(4'hf), ra);
      endcase
    end

`ifdef ALU_MULDIV_MACC_EN
    quick_op("macc_mthi0", ALU_FUNC_MTHI, 4'h0);
    quick_op("macc_mtlo1", ALU_FUNC_MTLO, 4'h1);
    run_op("madd_2x3", ALU_FUNC_MADD, 4'h2, 4'h3);
    chk("madd_2x3/lo7", lo1, 4'h7);
    run_op("msubu_3x3", ALU_FUNC_MSUBU, 4'h3, 4'h3);
    run_op("msub_fx2", ALU_FUNC_MSUB, 4'hf, 4'h2);
    run_op("maddu_fxf", ALU_FUNC_MADDU, 4'hf, 4'hf);
`else
    quick_op("madd_noop", ALU_FUNC_MADD, 4'h2);
    quick_op("msub_noop", ALU_FUNC_MSUB, 4'h3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
